// File: rtl/cf_math_pkg.sv
// Small math helpers shared across blocks; idx_width gives the width of an
// index into num_idx items, never less than one bit.
package cf_math_pkg;

  function automatic int unsigned idx_width(input int unsigned num_idx);
    return (num_idx > 32'd1) ? unsigned'($clog2(num_idx)) : 32'd1;
  endfunction

endpackage

// File: rtl/rel_arb_pkg.sv
// Shared constants and the round-robin pointer wrap rule for the
// radiation-hardened push arbiter.
package rel_arb_pkg;

  localparam int unsigned FaultCntWidth = 8;

  // Pointer moves one past the granted index, wrapping at num_req.
  function automatic int unsigned next_ptr(input int unsigned idx, input int unsigned num_req);
    return ((idx + 32'd1) >= num_req) ? 32'd0 : (idx + 32'd1);
  endfunction

endpackage

// File: rtl/rel_rr_push_arbiter_if.sv
// Requester/FIFO handshake bundle for rel_rr_push_arbiter; master is the
// requester + FIFO side, slave is the arbiter side.
interface rel_rr_push_arbiter_if #(
  parameter int unsigned NumReq    = 4,
  parameter int unsigned DataWidth = 32
);
  logic [NumReq-1:0]                req_valid;
  logic [NumReq-1:0]                req_ready;
  logic [NumReq-1:0][DataWidth-1:0] req_data;
  logic                             fifo_full;
  logic                             fifo_push;
  logic [DataWidth-1:0]             fifo_data;

  modport master (output req_valid, req_data, fifo_full,
                  input  req_ready, fifo_push, fifo_data);
  modport slave  (input  req_valid, req_data, fifo_full,
                  output req_ready, fifo_push, fifo_data);
endinterface

// File: rtl/TMR_voter_fail.sv
// Word-level majority of three copies; flags any disagreement between them.
module TMR_voter_fail #(
  parameter int unsigned DataWidth = 1
) (
  input  logic [DataWidth-1:0] a_i,
  input  logic [DataWidth-1:0] b_i,
  input  logic [DataWidth-1:0] c_i,
  output logic [DataWidth-1:0] majority_o,
  output logic                 fault_detected_o
);
  always_comb begin
    majority_o = b_i;
    if ((a_i == b_i) || (a_i == c_i)) majority_o = a_i;
  end

  assign fault_detected_o = !((a_i == b_i) && (a_i == c_i));
endmodule

// File: rtl/bitwise_TMR_voter_fail.sv
// Per-bit majority of three copies; flags any bit where the copies disagree.
module bitwise_TMR_voter_fail #(
  parameter int unsigned DataWidth = 1
) (
  input  logic [DataWidth-1:0] a_i,
  input  logic [DataWidth-1:0] b_i,
  input  logic [DataWidth-1:0] c_i,
  output logic [DataWidth-1:0] majority_o,
  output logic                 fault_detected_o
);
  assign majority_o       = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
  assign fault_detected_o = |((a_i ^ b_i) | (a_i ^ c_i));
endmodule

// File: rtl/rel_rr_arb_tmr_part.sv
// One redundant copy of the round-robin state: pointer register, cyclic
// search from the voted pointer, and next-pointer selection.
module rel_rr_arb_tmr_part
  import rel_arb_pkg::*;
#(
  parameter int unsigned NumReq   = 4,
  parameter int unsigned IdxWidth = 2
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                flush_i,
  input  logic                push_i,
  input  logic [NumReq-1:0]   req_valid_i,
  input  logic [IdxWidth-1:0] ptr_voted_i,
  input  logic [IdxWidth-1:0] gnt_voted_i,
  output logic [IdxWidth-1:0] ptr_o,
  output logic [IdxWidth-1:0] gnt_o
);
  logic [IdxWidth-1:0] ptr_d, ptr_q;
  logic [IdxWidth-1:0] gnt_lo, gnt_hi;
  logic                hit_lo, hit_hi;

  // Descending scan leaves the lowest valid index overall and the lowest at or
  // above the pointer; the latter wins, the former covers the wrap.
  always_comb begin
    gnt_lo = '0;
    gnt_hi = '0;
    hit_lo = 1'b0;
    hit_hi = 1'b0;
    for (int i = NumReq - 1; i >= 0; i--) begin
      if (req_valid_i[IdxWidth'(i)]) begin
        gnt_lo = IdxWidth'(i);
        hit_lo = 1'b1;
        if (IdxWidth'(i) >= ptr_voted_i) begin
          gnt_hi = IdxWidth'(i);
          hit_hi = 1'b1;
        end
      end
    end
    gnt_o = hit_hi ? gnt_hi : (hit_lo ? gnt_lo : ptr_voted_i);
  end

  // Always reload from voted values so a lone upset heals on the next edge.
  always_comb begin
    ptr_d = ptr_voted_i;
    if (flush_i)     ptr_d = '0;
    else if (push_i) ptr_d = IdxWidth'(next_ptr(32'(gnt_voted_i), NumReq));
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) ptr_q <= '0;
    else         ptr_q <= ptr_d;
  end

  assign ptr_o = ptr_q;
endmodule

// File: rtl/rel_rr_push_arbiter.sv
// TMR-protected round-robin arbiter pushing one requester per cycle into a
// downstream FIFO. Define REL_ARB_FAULT_CNT_EN to add the saturating fault counter.
module rel_rr_push_arbiter
  import rel_arb_pkg::*;
#(
  parameter int unsigned NumReq    = 4,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned IdxWidth  = cf_math_pkg::idx_width(NumReq)
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             flush_i,
  input  logic [NumReq-1:0]                req_valid_i,
  input  logic [NumReq-1:0][DataWidth-1:0] req_data_i,
  output logic [NumReq-1:0]                req_ready_o,
  input  logic                             fifo_full_i,
  output logic                             fifo_push_o,
  output logic [DataWidth-1:0]             fifo_data_o,
  output logic [IdxWidth-1:0]              grant_idx_o,
  output logic                             fault_o,
  output logic [FaultCntWidth-1:0]         fault_cnt_o
);
  logic [2:0][IdxWidth-1:0] ptr_copy, gnt_copy;
  logic [IdxWidth-1:0]      ptr_voted, gnt_voted;
  logic                     ptr_fault, gnt_fault;
  logic                     push;

  for (genvar c = 0; c < 3; c++) begin : gen_part
    (* no_ungroup *)
    (* no_boundary_optimization *)
    rel_rr_arb_tmr_part #(
      .NumReq  (NumReq),
      .IdxWidth(IdxWidth)
    ) i_part (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .flush_i    (flush_i),
      .push_i     (push),
      .req_valid_i(req_valid_i),
      .ptr_voted_i(ptr_voted),
      .gnt_voted_i(gnt_voted),
      .ptr_o      (ptr_copy[c]),
      .gnt_o      (gnt_copy[c])
    );
  end

  bitwise_TMR_voter_fail #(.DataWidth(IdxWidth)) i_ptr_vote (
    .a_i             (ptr_copy[0]),
    .b_i             (ptr_copy[1]),
    .c_i             (ptr_copy[2]),
    .majority_o      (ptr_voted),
    .fault_detected_o(ptr_fault)
  );

  TMR_voter_fail #(.DataWidth(IdxWidth)) i_gnt_vote (
    .a_i             (gnt_copy[0]),
    .b_i             (gnt_copy[1]),
    .c_i             (gnt_copy[2]),
    .majority_o      (gnt_voted),
    .fault_detected_o(gnt_fault)
  );

  // Reset gates the push combinationally so no handshake survives it.
  assign push        = (|req_valid_i) && !fifo_full_i && rst_ni;
  assign fifo_push_o = push;
  assign fifo_data_o = push ? req_data_i[gnt_voted] : '0;
  assign grant_idx_o = gnt_voted;
  assign fault_o     = ptr_fault | gnt_fault;

  always_comb begin
    req_ready_o = '0;
    for (int i = 0; i < NumReq; i++) begin
      req_ready_o[i] = push && (gnt_voted == IdxWidth'(i));
    end
  end

`ifdef REL_ARB_FAULT_CNT_EN
  logic [FaultCntWidth-1:0] fault_cnt_d, fault_cnt_q;

  always_comb begin
    fault_cnt_d = fault_cnt_q;
    if (flush_i)                             fault_cnt_d = '0;
    else if (fault_o && (fault_cnt_q != '1)) fault_cnt_d = fault_cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) fault_cnt_q <= '0;
    else         fault_cnt_q <= fault_cnt_d;
  end

  assign fault_cnt_o = fault_cnt_q;
`else
  assign fault_cnt_o = '0;
`endif
endmodule

// File: tb/tb_rel_rr_push_arbiter.sv
// Directed corner cases plus randomized traffic against a queue-free
// round-robin reference model for rel_rr_push_arbiter.
module tb_rel_rr_push_arbiter;
  localparam int N  = 4;
  localparam int DW = 32;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       flush;
  logic [1:0] gidx;
  logic       fault;
  logic [7:0] fault_cnt;

  rel_rr_push_arbiter_if #(.NumReq(N), .DataWidth(DW)) bus ();

  rel_rr_push_arbiter #(.NumReq(N), .DataWidth(DW)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .flush_i    (flush),
    .req_valid_i(bus.req_valid),
    .req_data_i (bus.req_data),
    .req_ready_o(bus.req_ready),
    .fifo_full_i(bus.fifo_full),
    .fifo_push_o(bus.fifo_push),
    .fifo_data_o(bus.fifo_data),
    .grant_idx_o(gidx),
    .fault_o    (fault),
    .fault_cnt_o(fault_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int ptr_m  = 0;
  int cnt_m  = 0;
  bit inj    = 1'b0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  // Reference: first valid index scanning upward from ptr with wrap, -1 if none.
  function automatic int model_grant(input int p, input logic [N-1:0] v);
    for (int k = 0; k < N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  // Called just after a negedge with inputs driven; checks, then crosses one posedge.
  task automatic step(input int want_g = -2);
    int          g;
    logic        e_push;
    logic [N-1:0] e_rdy;
    logic [DW-1:0] e_data;
    #1;
    g      = model_grant(ptr_m, bus.req_valid);
    e_push = (g >= 0) && !bus.fifo_full && rst_n;
    e_rdy  = '0;
    e_data = '0;
    if (e_push) begin
      e_rdy[g] = 1'b1;
      e_data   = bus.req_data[g];
    end
    chk("push", bus.fifo_push, e_push);
    chk("ready", bus.req_ready, e_rdy);
    chk("data", bus.fifo_data, e_data);
    chk("fault_cnt", fault_cnt, cnt_m);
    if (rst_n) begin
      chk("grant_idx", gidx, (g >= 0) ? g : ptr_m);
      chk("fault", fault, inj);
    end
    if (want_g != -2) chk("directed_grant", gidx, want_g);
    @(posedge clk);
    if (!rst_n)      ptr_m = 0;
    else if (flush)  ptr_m = 0;
    else if (e_push) ptr_m = (g + 1) % N;
`ifdef REL_ARB_FAULT_CNT_EN
    if (!rst_n || flush)         cnt_m = 0;
    else if (inj && cnt_m < 255) cnt_m++;
`endif
    @(negedge clk);
  endtask

  task automatic drive(input logic [N-1:0] v, input logic full, input logic fl, input logic rn);
    bus.req_valid = v;
    bus.fifo_full = full;
    flush         = fl;
    rst_n         = rn;
    for (int i = 0; i < N; i++) bus.req_data[i] = $urandom;
  endtask

  initial begin
    drive(4'b1011, 1'b0, 1'b0, 1'b0);
    step();
    drive(4'b1111, 1'b0, 1'b0, 1'b0);
    step();
    drive(4'b0000, 1'b0, 1'b0, 1'b1);
    step(0);

    // Everyone valid: plain rotation, one push per cycle.
    for (int i = 0; i < 8; i++) begin
      drive(4'b1111, 1'b0, 1'b0, 1'b1);
      step(i % N);
    end

    // Wrap-around from ptr=3 to the only valid requester 1.
    drive(4'b0100, 1'b0, 1'b0, 1'b1); step(2);
    drive(4'b0010, 1'b0, 1'b0, 1'b1); step(1);
    drive(4'b0000, 1'b0, 1'b0, 1'b1); step(2);

    // FIFO full stalls everything; release grants in the same cycle.
    for (int i = 0; i < 3; i++) begin
      drive(4'b0100, 1'b1, 1'b0, 1'b1);
      step(2);
    end
    drive(4'b0100, 1'b0, 1'b0, 1'b1); step(2);

    // Single-copy upset on the pointer.
    drive(4'b0000, 1'b0, 1'b1, 1'b1); step(3);
    drive(4'b1111, 1'b1, 1'b0, 1'b1);
    dut.gen_part[1].i_part.ptr_q = 2'd2;
    inj = 1'b1;
    step(0);
    inj = 1'b0;
    chk("realign", dut.gen_part[1].i_part.ptr_q, ptr_m);
    drive(4'b1111, 1'b1, 1'b0, 1'b1); step(0);

    // Reset mid-stream with ptr=2.
    drive(4'b0010, 1'b0, 1'b0, 1'b1); step(1);
    drive(4'b0000, 1'b0, 1'b0, 1'b1); step(2);
    drive(4'b1111, 1'b0, 1'b0, 1'b0); step();
    drive(4'b0110, 1'b0, 1'b0, 1'b1); step(1);

    // Flush while granting requester 3.
    drive(4'b1000, 1'b0, 1'b1, 1'b1); step(3);
    drive(4'b0000, 1'b0, 1'b0, 1'b1); step(0);

    for (int c = 0; c < 400; c++) begin
      drive(4'($urandom_range(0, 15)), ($urandom_range(0, 9) < 3),
            ($urandom_range(0, 19) == 0), ($urandom_range(0, 49) != 0));
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rel_rr_push_arbiter.md
REL_RR_PUSH_ARBITER -- requirements
Module: rel_rr_push_arbiter

Interface
REQ-001 The block SHALL have parameter NumReq, default 4, giving the number of requesters (1..64).
REQ-002 The block SHALL have parameter DataWidth, default 32, giving the payload width, ECC bits included.
REQ-003 The block SHALL have parameter IdxWidth, default cf_math_pkg::idx_width(NumReq); it is derived and SHALL NOT be overridden.
REQ-004 The block SHALL have these ports, one per entry:
- clk_i, input, 1: the single clock.
- rst_ni, input, 1: reset, synchronous, active-low.
- flush_i, input, 1: return the arbiter to its reset state.
- req_valid_i, input, NumReq: requester valid.
- req_data_i, input, NumReq x DataWidth: requester payloads.
- req_ready_o, output, NumReq: requester ready.
- fifo_full_i, input, 1: full flag of the downstream FIFO.
- fifo_push_o, output, 1: push into the downstream FIFO.
- fifo_data_o, output, DataWidth: payload to the downstream FIFO.
- grant_idx_o, output, IdxWidth: index of the current grant (unprotected, debug only).
- fault_o, output, 1: a TMR voter mismatch occurred in this cycle.
- fault_cnt_o, output, 8: count of cycles with a voter mismatch.

Function
REQ-005 The priority pointer ptr SHALL be held in three register copies; each copy SHALL be updated from the bitwise majority of all three copies every cycle.
REQ-006 The grant g SHALL be the first index i with req_valid_i[i]=1, searching cyclically from voted ptr upward and wrapping from NumReq-1 to 0.
REQ-007 fifo_push_o SHALL be 1 exactly when any req_valid_i bit is 1, fifo_full_i=0 and rst_ni=1, with zero cycles of combinational latency.
REQ-008 req_ready_o[g] SHALL equal fifo_push_o; every other req_ready_o bit SHALL be 0.
REQ-009 fifo_data_o SHALL equal req_data_i[g] when fifo_push_o=1, and all zeros otherwise.
REQ-010 On a cycle with fifo_push_o=1, ptr SHALL become (g+1) mod NumReq at the next edge; on any other cycle ptr SHALL hold its voted value.
REQ-011 When fifo_full_i=1, all ready bits SHALL be 0 and ptr SHALL hold; valid inputs are not required to stay asserted.
REQ-012 When flush_i=1, ptr SHALL become 0 at the next edge, and the grant and push of that cycle SHALL still complete.
REQ-013 When NumReq=1, ptr SHALL be constant 0 and the block SHALL reduce to a pass-through gated by fifo_full_i.
REQ-014 fault_o SHALL be the OR of the pointer voter mismatch and the grant-index voter mismatch of the current cycle.
REQ-015 The grant index SHALL be computed separately in each copy and voted before it drives the data mux and the ready bits.
REQ-016 A single-copy upset SHALL be corrected by the next edge without any change to the voted outputs.
REQ-017 grant_idx_o SHALL show the voted g, or the voted ptr when no request is valid.

Reset
REQ-018 While rst_ni=0 at an edge, all three ptr copies SHALL become 0 and fault_cnt_o SHALL become 0.
REQ-019 While rst_ni=0, fifo_push_o and req_ready_o SHALL be 0 combinationally, which discards any in-flight handshake.
REQ-020 After reset the values SHALL be: fifo_data_o all zeros, fault_o 0 (no mismatch present), grant_idx_o 0.

Configuration
REQ-021 With macro REL_ARB_FAULT_CNT_EN defined, fault_cnt_o SHALL increment by 1 at each edge where fault_o=1, saturating at 255, and SHALL be cleared by flush_i.
REQ-022 Without REL_ARB_FAULT_CNT_EN, fault_cnt_o SHALL be tied to 0 and no counter flops SHALL exist.

Structure
REQ-023 Package rel_arb_pkg SHALL hold the fault-counter width constant (8) and a function next_ptr(idx, NumReq) implementing the wrap rule.
REQ-024 Each redundant copy SHALL be sub-module rel_rr_arb_tmr_part, containing the ptr register, its cyclic search and its next-ptr logic.
REQ-025 rel_rr_arb_tmr_part SHALL carry the no_ungroup and no_boundary_optimization attributes.
REQ-026 Voting SHALL use bitwise_TMR_voter_fail and TMR_voter_fail.

Verification
REQ-027 NumReq=4, all valid, full=0 for 8 cycles -> grants 0,1,2,3,0,1,2,3, with one push per cycle.
REQ-028 ptr=3, only req 1 valid -> grant 1 through wrap-around, and next ptr=2.
REQ-029 full=1 for 3 cycles with req 2 valid -> push=0, all ready=0, ptr unchanged; full=0 -> grant 2 in that same cycle.
REQ-030 Force copy 1 of ptr to 2 while the other copies are 0 -> fault_o=1 for one cycle, grant unchanged, copies realigned to the voted value next cycle; fault_cnt_o=1 with REL_ARB_FAULT_CNT_EN.
REQ-031 Assert rst_ni=0 mid-stream with ptr=2 -> push=0 in that cycle, ptr=0 after the edge, first grant afterwards = lowest valid index.
REQ-032 flush_i=1 while granting req 3 -> push of req 3 completes, ptr=0 at the next edge.
